sram_arbiter_2to1: RTL and testbench

- Shares one SRAM controller request/response port between two requesters, m0 and m1. Typical pairing: the SRAM tester plus a display or debug reader.
- Arbitration is round-robin with grant locking. The arbiter holds the grant until the controller accepts the request.
- In-order read responses are routed back to the requester that issued each read, using a tag FIFO.
- Sits between the requester logic and the SRAM controller, which drives the SRAM IO pins.

---
 rtl/sram_arbiter_2to1.sv | 157 +++++++++++++++
 tb/tb_sram_arbiter_2to1.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_2to1.sv
// Two-port round-robin arbiter in front of one SRAM controller port.
// Grants lock until accepted; a tag FIFO routes in-order read data back to its issuer.
module sram_arbiter_2to1 #(
  parameter int ADDR_BITS = 20,
  parameter int DATA_BITS = 16,
  parameter int MAX_READS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 m0_req_valid,
  output logic                 m0_req_ready,
  input  logic                 m0_req_we,
  input  logic [ADDR_BITS-1:0] m0_req_addr,
  input  logic [DATA_BITS-1:0] m0_req_wdata,
  output logic                 m0_rsp_valid,
  output logic [DATA_BITS-1:0] m0_rsp_rdata,
  input  logic                 m1_req_valid,
  output logic                 m1_req_ready,
  input  logic                 m1_req_we,
  input  logic [ADDR_BITS-1:0] m1_req_addr,
  input  logic [DATA_BITS-1:0] m1_req_wdata,
  output logic                 m1_rsp_valid,
  output logic [DATA_BITS-1:0] m1_rsp_rdata,
  output logic                 s_req_valid,
  input  logic                 s_req_ready,
  output logic                 s_req_we,
  output logic [ADDR_BITS-1:0] s_req_addr,
  output logic [DATA_BITS-1:0] s_req_wdata,
  input  logic                 s_rsp_valid,
  input  logic [DATA_BITS-1:0] s_rsp_rdata,
  output logic                 rsp_orphan
);

  localparam int PTR_W = $clog2(MAX_READS);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {REQ_M0 = 1'b0, REQ_M1 = 1'b1} req_id_e;

  logic             lock_q, lock_d;
  req_id_e          owner_q, owner_d;
  req_id_e          rr_prefer_q, rr_prefer_d;
  req_id_e          tag_mem_q [MAX_READS];
  req_id_e          tag_mem_d [MAX_READS];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rsp_orphan_q, rsp_orphan_d;

  logic    fifo_empty, fifo_full, can_push;
  logic    pop, push, hs;
  logic    m0_elig, m1_elig, grant_valid;
  req_id_e sel, head;

  // Selection, forwarding mux and response routing.
  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    fifo_empty   = (count_q == '0);
    fifo_full    = (count_q == CNT_W'(MAX_READS));
    head         = tag_mem_q[rd_ptr_q];
    pop          = reset_n && s_rsp_valid && !fifo_empty;
    // A pop in the same cycle frees the slot, so a read may enter a full FIFO then.
    can_push     = !fifo_full || pop;
    m0_elig      = m0_req_valid && (m0_req_we || can_push);
    m1_elig      = m1_req_valid && (m1_req_we || can_push);

    sel          = rr_prefer_q;
    grant_valid  = 1'b0;
    if (lock_q) begin
      sel         = owner_q;
      grant_valid = (owner_q == REQ_M0) ? m0_elig : m1_elig;
    end else if (m0_elig && m1_elig) begin
      sel         = rr_prefer_q;
      grant_valid = 1'b1;
    end else if (m0_elig) begin
      sel         = REQ_M0;
      grant_valid = 1'b1;
    end else if (m1_elig) begin
      sel         = REQ_M1;
      grant_valid = 1'b1;
    end

    s_req_valid  = reset_n && grant_valid;
    s_req_we     = 1'b0;
    s_req_addr   = '0;
    s_req_wdata  = '0;
    if (s_req_valid) begin
      s_req_we    = (sel == REQ_M0) ? m0_req_we    : m1_req_we;
      s_req_addr  = (sel == REQ_M0) ? m0_req_addr  : m1_req_addr;
      s_req_wdata = (sel == REQ_M0) ? m0_req_wdata : m1_req_wdata;
    end
    m0_req_ready = s_req_valid && s_req_ready && (sel == REQ_M0);
    m1_req_ready = s_req_valid && s_req_ready && (sel == REQ_M1);
    hs           = s_req_valid && s_req_ready;
    push         = hs && !s_req_we;

    m0_rsp_valid = pop && (head == REQ_M0);
    m1_rsp_valid = pop && (head == REQ_M1);
    m0_rsp_rdata = m0_rsp_valid ? s_rsp_rdata : '0;
    m1_rsp_rdata = m1_rsp_valid ? s_rsp_rdata : '0;
    rsp_orphan   = rsp_orphan_q;
  end

  // Next-state for arbitration and the tag FIFO.
  always_comb begin
    lock_d       = lock_q;
    owner_d      = owner_q;
    rr_prefer_d  = rr_prefer_q;
    tag_mem_d    = tag_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rsp_orphan_d = rsp_orphan_q | (s_rsp_valid & fifo_empty);

    if (hs) begin
      lock_d      = 1'b0;
      rr_prefer_d = (sel == REQ_M0) ? REQ_M1 : REQ_M0;
    end else if (s_req_valid) begin
      lock_d  = 1'b1;
      owner_d = sel;
    end

    if (push) begin
      tag_mem_d[wr_ptr_q] = sel;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q       <= 1'b0;
      owner_q      <= REQ_M0;
      rr_prefer_q  <= REQ_M0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rsp_orphan_q <= 1'b0;
      // NOTE: the tag store is a handful of flops, so it is reset like the rest; a large RAM would not be.
      for (int i = 0; i < MAX_READS; i++) begin
        tag_mem_q[i] <= REQ_M0;
      end
    end else begin
      lock_q       <= lock_d;
      owner_q      <= owner_d;
      rr_prefer_q  <= rr_prefer_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rsp_orphan_q <= rsp_orphan_d;
      tag_mem_q    <= tag_mem_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter_2to1.sv
// Directed bench for sram_arbiter_2to1: a queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_sram_arbiter_2to1;

  localparam int AB = 20;
  localparam int DB = 16;
  localparam int MR = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          m0_req_valid, m0_req_ready, m0_req_we;
  logic [AB-1:0] m0_req_addr;
  logic [DB-1:0] m0_req_wdata;
  logic          m0_rsp_valid;
  logic [DB-1:0] m0_rsp_rdata;
  logic          m1_req_valid, m1_req_ready, m1_req_we;
  logic [AB-1:0] m1_req_addr;
  logic [DB-1:0] m1_req_wdata;
  logic          m1_rsp_valid;
  logic [DB-1:0] m1_rsp_rdata;
  logic          s_req_valid, s_req_ready, s_req_we;
  logic [AB-1:0] s_req_addr;
  logic [DB-1:0] s_req_wdata;
  logic          s_rsp_valid;
  logic [DB-1:0] s_rsp_rdata;
  logic          rsp_orphan;

  int checks   = 0;
  int failures = 0;

  sram_arbiter_2to1 #(.ADDR_BITS(AB), .DATA_BITS(DB), .MAX_READS(MR)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_we(s_req_we),
    .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata),
    .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata),
    .rsp_orphan(rsp_orphan)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding reads as a queue of issuer ids, a held grant, a preferred id.
  int unsigned tags[$];
  int          held     = -1;
  int          prefer   = 0;
  logic        orphan_m = 1'b0;
  int          grants[2];

  always @(negedge clk) begin
    logic          v[2], w[2];
    logic [AB-1:0] a[2];
    logic [DB-1:0] d[2];
    logic          pop_ok, room, want0, want1;
    int            g;
    v[0] = m0_req_valid; w[0] = m0_req_we; a[0] = m0_req_addr; d[0] = m0_req_wdata;
    v[1] = m1_req_valid; w[1] = m1_req_we; a[1] = m1_req_addr; d[1] = m1_req_wdata;
    if (!reset_n) begin
      check("rst_s_req_valid", 32'(s_req_valid), 32'd0);
      check("rst_s_req_addr", 32'(s_req_addr), 32'd0);
      check("rst_readys", {30'd0, m1_req_ready, m0_req_ready}, 32'd0);
      check("rst_rsp_valids", {30'd0, m1_rsp_valid, m0_rsp_valid}, 32'd0);
      check("rst_orphan", 32'(rsp_orphan), 32'd0);
      tags.delete();
      held     = -1;
      prefer   = 0;
      orphan_m = 1'b0;
    end else begin
      pop_ok = s_rsp_valid && (tags.size() > 0);
      room   = (tags.size() < MR) || pop_ok;
      want0  = v[0] && (w[0] || room);
      want1  = v[1] && (w[1] || room);
      if (held >= 0)          g = held;
      else if (want0 && want1) g = prefer;
      else if (want0)         g = 0;
      else if (want1)         g = 1;
      else                    g = -1;

      check("m_s_req_valid", 32'(s_req_valid), 32'(g >= 0));
      check("m_s_req_we", 32'(s_req_we), (g >= 0) ? 32'(w[g]) : 32'd0);
      check("m_s_req_addr", 32'(s_req_addr), (g >= 0) ? 32'(a[g]) : 32'd0);
      check("m_s_req_wdata", 32'(s_req_wdata), (g >= 0) ? 32'(d[g]) : 32'd0);
      check("m_m0_req_ready", 32'(m0_req_ready), 32'(g == 0 && s_req_ready));
      check("m_m1_req_ready", 32'(m1_req_ready), 32'(g == 1 && s_req_ready));
      check("m_m0_rsp_valid", 32'(m0_rsp_valid), 32'(pop_ok && tags[0] == 0));
      check("m_m1_rsp_valid", 32'(m1_rsp_valid), 32'(pop_ok && tags[0] == 1));
      check("m_m0_rsp_rdata", 32'(m0_rsp_rdata), (pop_ok && tags[0] == 0) ? 32'(s_rsp_rdata) : 32'd0);
      check("m_m1_rsp_rdata", 32'(m1_rsp_rdata), (pop_ok && tags[0] == 1) ? 32'(s_rsp_rdata) : 32'd0);
      check("m_rsp_orphan", 32'(rsp_orphan), 32'(orphan_m));

      if (s_rsp_valid && tags.size() == 0) orphan_m = 1'b1;
      if (pop_ok) void'(tags.pop_front());
      if (g >= 0 && s_req_ready) begin
        if (!w[g]) tags.push_back(g);
        grants[g]++;
        prefer = 1 - g;
        held   = -1;
      end else if (g >= 0) begin
        held = g;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req_valid = 0; m0_req_we = 0; m0_req_addr = '0; m0_req_wdata = '0;
    m1_req_valid = 0; m1_req_we = 0; m1_req_addr = '0; m1_req_wdata = '0;
    s_req_ready  = 1; s_rsp_valid = 0; s_rsp_rdata = '0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle_inputs();
    m0_req_valid = 1;  // a live request must not leak out while in reset
    @(negedge clk);
    check("rst_gate_s_req_valid", 32'(s_req_valid), 32'd0);
    tick();
    m0_req_valid = 0;
    reset_n = 1;
  endtask

  initial begin
    reset_n = 0;
    idle_inputs();
    #1;
    do_reset();

    // Single requester read with zero-wait controller.
    m0_req_valid = 1; m0_req_we = 0; m0_req_addr = 20'h00010;
    @(negedge clk);
    check("t1_m0_ready", 32'(m0_req_ready), 32'd1);
    check("t1_addr", 32'(s_req_addr), 32'h10);
    tick();
    idle_inputs();
    s_rsp_valid = 1; s_rsp_rdata = 16'hBEEF;
    @(negedge clk);
    check("t1_m0_rsp_valid", 32'(m0_rsp_valid), 32'd1);
    check("t1_m0_rsp_rdata", 32'(m0_rsp_rdata), 32'hBEEF);
    check("t1_m1_rsp_valid", 32'(m1_rsp_valid), 32'd0);
    tick();
    idle_inputs();

    // Contention: both write continuously from reset, grants must alternate.
    do_reset();
    grants[0] = 0; grants[1] = 0;
    m0_req_valid = 1; m0_req_we = 1; m0_req_addr = 20'h00100; m0_req_wdata = 16'h0A0A;
    m1_req_valid = 1; m1_req_we = 1; m1_req_addr = 20'h00200; m1_req_wdata = 16'h0B0B;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("t2_alt_addr", 32'(s_req_addr), (i % 2 == 0) ? 32'h100 : 32'h200);
      tick();
    end
    check("t2_m0_grants", 32'(grants[0]), 32'd8);
    check("t2_m1_grants", 32'(grants[1]), 32'd8);
    idle_inputs();

    // Lock: m1 stalled 3 cycles; m0 arrives meanwhile and must wait.
    m1_req_valid = 1; m1_req_we = 1; m1_req_addr = 20'h00300; s_req_ready = 0;
    @(negedge clk);
    check("t3_c1_addr", 32'(s_req_addr), 32'h300);
    tick();
    m0_req_valid = 1; m0_req_we = 1; m0_req_addr = 20'h00400;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t3_locked_addr", 32'(s_req_addr), 32'h300);
      check("t3_locked_m0_ready", 32'(m0_req_ready), 32'd0);
      tick();
    end
    s_req_ready = 1;
    @(negedge clk);
    check("t3_m1_accept", 32'(m1_req_ready), 32'd1);
    tick();
    m1_req_valid = 0;
    @(negedge clk);
    check("t3_m0_next", 32'(m0_req_ready), 32'd1);
    check("t3_m0_addr", 32'(s_req_addr), 32'h400);
    tick();
    idle_inputs();

    // Read FIFO full: four reads fill it, the fifth stalls until a pop.
    do_reset();
    m0_req_valid = 1; m0_req_we = 0;
    for (int i = 0; i < 4; i++) begin
      m0_req_addr = 20'(32'h10 + i);
      @(negedge clk);
      check("t4_fill_ready", 32'(m0_req_ready), 32'd1);
      tick();
    end
    m0_req_addr  = 20'h00014;
    m1_req_valid = 1; m1_req_we = 1; m1_req_addr = 20'h00500;
    @(negedge clk);
    check("t4_full_m0_stall", 32'(m0_req_ready), 32'd0);
    check("t4_full_m1_write", 32'(m1_req_ready), 32'd1);
    check("t4_full_addr", 32'(s_req_addr), 32'h500);
    tick();
    m1_req_valid = 0; m1_req_we = 0; m1_req_addr = '0;
    @(negedge clk);
    check("t4_still_stalled", 32'(s_req_valid), 32'd0);
    tick();
    s_rsp_valid = 1; s_rsp_rdata = 16'h00A0;
    @(negedge clk);
    check("t4_pop_unblocks", 32'(m0_req_ready), 32'd1);
    check("t4_pop_rsp", 32'(m0_rsp_valid), 32'd1);
    tick();
    m0_req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      s_rsp_rdata = 16'(32'hA1 + i);
      tick();
    end
    idle_inputs();

    // Interleaved reads routed back in issue order.
    m0_req_valid = 1; m0_req_we = 0; m0_req_addr = 20'h0000A;
    tick();
    m0_req_valid = 0; m1_req_valid = 1; m1_req_we = 0; m1_req_addr = 20'h0000B;
    tick();
    m1_req_valid = 0; m0_req_valid = 1; m0_req_addr = 20'h0000C;
    tick();
    idle_inputs();
    s_rsp_valid = 1; s_rsp_rdata = 16'h1111;
    @(negedge clk);
    check("t5_r1_m0", {m1_rsp_valid, m0_rsp_valid, 14'd0, m0_rsp_rdata}, {2'b01, 14'd0, 16'h1111});
    tick();
    s_rsp_rdata = 16'h2222;
    @(negedge clk);
    check("t5_r2_m1", {m1_rsp_valid, m0_rsp_valid, 14'd0, m1_rsp_rdata}, {2'b10, 14'd0, 16'h2222});
    tick();
    s_rsp_rdata = 16'h3333;
    @(negedge clk);
    check("t5_r3_m0", {m1_rsp_valid, m0_rsp_valid, 14'd0, m0_rsp_rdata}, {2'b01, 14'd0, 16'h3333});
    tick();
    idle_inputs();

    // Reset with two reads outstanding, then late responses are orphans.
    m0_req_valid = 1; m0_req_we = 0; m0_req_addr = 20'h00020;
    tick();
    m0_req_addr = 20'h00021;
    tick();
    idle_inputs();
    do_reset();
    s_rsp_valid = 1; s_rsp_rdata = 16'h5555;
    @(negedge clk);
    check("t6_no_route", {30'd0, m1_rsp_valid, m0_rsp_valid}, 32'd0);
    check("t6_orphan_before", 32'(rsp_orphan), 32'd0);
    tick();
    s_rsp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_orphan_sticky", 32'(rsp_orphan), 32'd1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
